io_bus_ctrl: RTL and testbench

- Sequences every CPU load/store into the I/O half of the physical map and completes each one as a single-outstanding transaction.
- Decodes the I/O region: LED, switch or VGA device, else unmapped.
- Drives a strobe/ack handshake to the selected peripheral and returns read data and an error flag to the CPU data port.
- Sits between the CPU data-memory interface and the LED/SW/VGA peripherals.

---
 rtl/raisin64_io_pkg.sv | 29 ++
 rtl/io_watchdog.sv | 29 ++
 rtl/io_bus_ctrl.sv | 115 +++++++++++
 tb/tb_io_bus_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/raisin64_io_pkg.sv
// Shared constants for the raisin64 I/O region: device pages, device indices,
// bus-controller states and the page decoder.
package raisin64_io_pkg;

  localparam logic [32:0] IO_LED_PAGE = 33'h100000001;
  localparam logic [32:0] IO_SW_PAGE  = 33'h100000002;
  localparam logic [32:0] IO_VGA_PAGE = 33'h100000003;

  localparam int DEV_LED = 0;
  localparam int DEV_SW  = 1;
  localparam int DEV_VGA = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } io_state_e;

  // Bit 46 of the page is the io flag, so low-half addresses never match a page.
  function automatic logic [2:0] io_decode(input logic [32:0] page);
    logic [2:0] sel;
    sel = 3'b000;
    if (page == IO_LED_PAGE) sel[DEV_LED] = 1'b1;
    else if (page == IO_SW_PAGE) sel[DEV_SW] = 1'b1;
    else if (page == IO_VGA_PAGE) sel[DEV_VGA] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/io_watchdog.sv
// Access timeout counter: cleared outside ACCESS, counts unacknowledged ACCESS
// cycles and flags expiry on the last allowed cycle. Used only with IO_TIMEOUT_EN.
module io_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/io_bus_ctrl.sv
// I/O bus controller: decodes CPU accesses to the I/O half of the map and runs one
// strobe/ack transaction at a time. Define IO_TIMEOUT_EN to add the access watchdog.
module io_bus_ctrl
  import raisin64_io_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [63:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              dev_stb,
  output logic [2:0]        dev_sel,
  output logic              dev_we,
  output logic [13:0]       dev_addr,
  output logic [DATA_W-1:0] dev_wdata,
  input  logic [2:0]        dev_ack,
  input  logic [DATA_W-1:0] led_rdata,
  input  logic [DATA_W-1:0] sw_rdata,
  input  logic [DATA_W-1:0] vga_rdata
);

  io_state_e         state;
  logic [2:0]        sel_q;
  logic [2:0]        req_sel;
  logic              sel_ack;
  logic              expire;
  logic [DATA_W-1:0] rdata_mux;
  logic              unused_addr_hi;

  // Upper address bits are only sign extension of bit 46.
  assign unused_addr_hi = ^cpu_addr[63:47];

  assign req_sel = io_decode(cpu_addr[46:14]);
  assign sel_ack = |(dev_ack & sel_q);

`ifdef IO_TIMEOUT_EN
  io_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != ACCESS),
    .enable(state == ACCESS && !sel_ack),
    .expire(expire)
  );
`else
  // Without the watchdog an access never expires; TIMEOUT has no effect.
  assign expire = (TIMEOUT < 0);
`endif

  always_comb begin
    rdata_mux = '0;
    if (sel_q[DEV_LED]) rdata_mux = led_rdata;
    else if (sel_q[DEV_SW]) rdata_mux = sw_rdata;
    else if (sel_q[DEV_VGA]) rdata_mux = vga_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 3'b000;
      dev_we    <= 1'b0;
      dev_addr  <= 14'd0;
      dev_wdata <= '0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            dev_we    <= cpu_we;
            dev_addr  <= cpu_addr[13:0];
            dev_wdata <= cpu_wdata;
            sel_q     <= req_sel;
            if (|req_sel) begin
              state <= ACCESS;
            end else begin
              cpu_rdata <= '0;
              cpu_err   <= 1'b1;
              state     <= RESP;
            end
          end
        end
        ACCESS: begin
          // A device ack takes priority over a simultaneous watchdog expiry.
          if (sel_ack) begin
            cpu_rdata <= dev_we ? '0 : rdata_mux;
            cpu_err   <= 1'b0;
            state     <= RESP;
          end else if (expire) begin
            cpu_rdata <= '0;
            cpu_err   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_ready = (state == IDLE);
  assign cpu_ack   = (state == RESP);
  assign dev_stb   = (state == ACCESS);
  assign dev_sel   = (state == ACCESS) ? sel_q : 3'b000;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed testbench for io_bus_ctrl: table of transactions plus hand-written
// reset-abort and (with IO_TIMEOUT_EN) timeout sequences.
module tb_io_bus_ctrl;

  localparam int DATA_W = 64;
  localparam logic [63:0] LED_VAL = 64'h1111_2222_3333_4444;
  localparam logic [63:0] SW_VAL  = 64'h0000_0000_0000_005A;
  localparam logic [63:0] VGA_VAL = 64'hDEAD_BEEF_CAFE_F00D;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [63:0]       cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ready;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;
  logic              dev_stb;
  logic [2:0]        dev_sel;
  logic              dev_we;
  logic [13:0]       dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic [2:0]        dev_ack = 3'b000;
  logic [DATA_W-1:0] led_rdata = LED_VAL;
  logic [DATA_W-1:0] sw_rdata = SW_VAL;
  logic [DATA_W-1:0] vga_rdata = VGA_VAL;

  int tests = 0;
  int fails = 0;

  io_bus_ctrl #(
    .DATA_W (DATA_W),
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_err  (cpu_err),
    .dev_stb  (dev_stb),
    .dev_sel  (dev_sel),
    .dev_we   (dev_we),
    .dev_addr (dev_addr),
    .dev_wdata(dev_wdata),
    .dev_ack  (dev_ack),
    .led_rdata(led_rdata),
    .sw_rdata (sw_rdata),
    .vga_rdata(vga_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          ack_at;
    logic [2:0]  ack_bits;
    logic [2:0]  stray_bits;
    logic [2:0]  exp_sel;
    logic [13:0] exp_daddr;
    logic [63:0] exp_rdata;
    logic        chk_rdata;
    logic        exp_err;
    int          exp_stb;
    int          exp_lat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one transaction from request to the cycle after cpu_ack.
  task automatic applyStimulus(input vec_t v);
    int stb;
    int lat;
    bit got;
    stb = 0;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    checkOutput({v.name, ".ready"}, 64'(cpu_ready), 64'd1);
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cpu_ack) begin
        got = 1'b1;
        lat = cyc;
        break;
      end
      dev_ack = 3'b000;
      if (dev_stb) begin
        stb++;
        checkOutput({v.name, ".sel"}, 64'(dev_sel), 64'(v.exp_sel));
        if (stb == 1) begin
          checkOutput({v.name, ".dev_we"}, 64'(dev_we), 64'(v.we));
          checkOutput({v.name, ".dev_addr"}, 64'(dev_addr), 64'(v.exp_daddr));
          checkOutput({v.name, ".dev_wdata"}, dev_wdata, v.wdata);
        end
        if (stb == v.ack_at) dev_ack = v.ack_bits;
        else if (v.ack_at == 0 || stb < v.ack_at) dev_ack = v.stray_bits;
      end
      @(negedge clk);
    end
    dev_ack = 3'b000;
    checkOutput({v.name, ".ack_seen"}, 64'(got), 64'd1);
    if (got) begin
      checkOutput({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
      checkOutput({v.name, ".stb_cycles"}, 64'(stb), 64'(v.exp_stb));
      checkOutput({v.name, ".err"}, 64'(cpu_err), 64'(v.exp_err));
      checkOutput({v.name, ".resp_stb"}, 64'(dev_stb), 64'd0);
      if (v.chk_rdata) checkOutput({v.name, ".rdata"}, cpu_rdata, v.exp_rdata);
      @(negedge clk);
      checkOutput({v.name, ".ack_pulse"}, 64'(cpu_ack), 64'd0);
      checkOutput({v.name, ".ready_after"}, 64'(cpu_ready), 64'd1);
      checkOutput({v.name, ".err_hold"}, 64'(cpu_err), 64'(v.exp_err));
      if (v.chk_rdata) checkOutput({v.name, ".rdata_hold"}, cpu_rdata, v.exp_rdata);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".ready"}, 64'(cpu_ready), 64'd1);
    checkOutput({tag, ".ack"}, 64'(cpu_ack), 64'd0);
    checkOutput({tag, ".err"}, 64'(cpu_err), 64'd0);
    checkOutput({tag, ".rdata"}, cpu_rdata, 64'd0);
    checkOutput({tag, ".stb"}, 64'(dev_stb), 64'd0);
    checkOutput({tag, ".sel"}, 64'(dev_sel), 64'd0);
    checkOutput({tag, ".dev_we"}, 64'(dev_we), 64'd0);
    checkOutput({tag, ".dev_addr"}, 64'(dev_addr), 64'd0);
    checkOutput({tag, ".dev_wdata"}, dev_wdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    vec_t vecs[10];
    vec_t v;
    int stb;

    vecs[0] = '{"sw_load", 1'b0, 64'hFFFFC00000008000, 64'h0, 2, 3'b010, 3'b000,
                3'b010, 14'h0, SW_VAL, 1'b1, 1'b0, 2, 3};
    vecs[1] = '{"led_store", 1'b1, 64'hFFFFC00000004010, 64'hFF, 5, 3'b001, 3'b000,
                3'b001, 14'h010, 64'h0, 1'b1, 1'b0, 5, 6};
    vecs[2] = '{"unmapped_low", 1'b0, 64'h0000000000001000, 64'h0, 0, 3'b000, 3'b000,
                3'b000, 14'h0, 64'h0, 1'b0, 1'b1, 0, 1};
    vecs[3] = '{"vga_stray", 1'b0, 64'hFFFFC0000000C000, 64'h0, 11, 3'b100, 3'b001,
                3'b100, 14'h0, VGA_VAL, 1'b1, 1'b0, 11, 12};
    vecs[4] = '{"led_load_fast", 1'b0, 64'hFFFFC00000007FFF, 64'h77, 1, 3'b001, 3'b000,
                3'b001, 14'h3FFF, LED_VAL, 1'b1, 1'b0, 1, 2};
    vecs[5] = '{"vga_store", 1'b1, 64'hFFFFC0000000C123, 64'h123456789, 1, 3'b100, 3'b000,
                3'b100, 14'h123, 64'h0, 1'b1, 1'b0, 1, 2};
    vecs[6] = '{"unmapped_page0", 1'b0, 64'hFFFFC00000000000, 64'h0, 0, 3'b000, 3'b000,
                3'b000, 14'h0, 64'h0, 1'b0, 1'b1, 0, 1};
    vecs[7] = '{"unmapped_page4", 1'b1, 64'hFFFFC00000010000, 64'h5, 0, 3'b000, 3'b000,
                3'b000, 14'h0, 64'h0, 1'b0, 1'b1, 0, 1};
    vecs[8] = '{"unmapped_io0", 1'b0, 64'h0000000000004000, 64'h0, 0, 3'b000, 3'b000,
                3'b000, 14'h0, 64'h0, 1'b0, 1'b1, 0, 1};
    vecs[9] = '{"sw_two_stray", 1'b0, 64'hFFFFC0000000BFF8, 64'h0, 4, 3'b010, 3'b101,
                3'b010, 14'h3FF8, SW_VAL, 1'b1, 1'b0, 4, 5};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Reset asserted in the third ACCESS cycle must abort without an ack.
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 64'hFFFFC00000008000;
    @(negedge clk);
    cpu_req = 1'b0;
    stb = 0;
    for (int i = 0; i < 10; i++) begin
      if (dev_stb) stb++;
      if (stb == 3) break;
      @(negedge clk);
    end
    checkOutput("rst_mid.reached_access3", 64'(stb), 64'd3);
    rst_n = 1'b0;
    #1;
    checkResetState("rst_mid");
    dev_ack = 3'b010;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_mid.no_ack", 64'(cpu_ack), 64'd0);
      checkOutput("rst_mid.ready", 64'(cpu_ready), 64'd1);
      checkOutput("rst_mid.no_stb", 64'(dev_stb), 64'd0);
    end
    dev_ack = 3'b000;
    applyStimulus(vecs[0]);

`ifdef IO_TIMEOUT_EN
    v = '{"sw_timeout", 1'b0, 64'hFFFFC00000008000, 64'h0, 0, 3'b000, 3'b000,
          3'b010, 14'h0, 64'h0, 1'b1, 1'b1, 16, 17};
    applyStimulus(v);
    v = '{"led_stray_timeout", 1'b0, 64'hFFFFC00000004000, 64'h0, 0, 3'b000, 3'b110,
          3'b001, 14'h0, 64'h0, 1'b1, 1'b1, 16, 17};
    applyStimulus(v);
`else
    v = vecs[3];
    applyStimulus(v);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
